dmem_access_ctrl: RTL and testbench
===================================

DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the maximum cycles spent in REQ plus WAIT_RSP before the access is aborted.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 ex_valid  in  1  MEM-stage instruction valid (is_valid).
REQ-005 ex_mem_rd / ex_mem_wr  in  1 each  load / store request.
REQ-006 ex_addr  in  64  byte address (ALU result).
REQ-007 ex_wdata  in  64  store data (rs2).
REQ-008 ex_unit  in  2  access size: 00 byte, 01 half, 10 word, 11 double.
REQ-009 ex_ext  in  1  load extension: 0 sign-extend, 1 zero-extend.
REQ-010 stall_o  out  1  pipeline hold.
REQ-011 dmem_req, dmem_we  out  1 each  memory request, write enable.
REQ-012 dmem_addr  out  64  doubleword-aligned address (ex_addr[2:0] forced to 0).
REQ-013 dmem_be  out  8  byte enables; dmem_wdata  out  64  lane-aligned store data.
REQ-014 dmem_gnt, dmem_rvalid  in  1 each; dmem_rdata  in  64.
REQ-015 ld_data  out  64  aligned, extended load result; ld_valid  out  1.
REQ-016 misalign_o, bus_err_o  out  1 each  single-cycle error pulses.

Function
REQ-017 States SHALL be IDLE, REQ, WAIT_RSP, DONE.
REQ-018 Accept condition: state IDLE, ex_valid=1, (ex_mem_rd|ex_mem_wr)=1, address aligned; on accept, addr/be/wdata/we/unit/ext SHALL be latched and the FSM SHALL enter REQ.
REQ-019 With both ex_mem_rd and ex_mem_wr set, the access SHALL be treated as a load.
REQ-020 Misaligned: half with addr[0]!=0, word with addr[1:0]!=0, double with addr[2:0]!=0; the block SHALL then issue no request, pulse misalign_o for one cycle (registered, next cycle), and remain in IDLE.
REQ-021 stall_o SHALL be 1 when state is REQ or WAIT_RSP, or combinationally when the accept condition holds in IDLE; 0 in DONE and otherwise.
REQ-022 dmem_req SHALL equal 1 exactly in REQ; dmem_addr/be/wdata/we SHALL remain stable until dmem_gnt is sampled high.
REQ-023 REQ + dmem_gnt: store -> DONE, load -> WAIT_RSP.
REQ-024 WAIT_RSP + dmem_rvalid: capture dmem_rdata, enter DONE; dmem_rvalid in any other state SHALL be ignored.
REQ-025 DONE SHALL last one cycle, pulse ld_valid=1 for loads only, and return to IDLE; a new access SHALL be accepted no earlier than the following IDLE cycle.
REQ-026 Store lanes: dmem_be = (01h/03h/0Fh/FFh by size) << addr[2:0]; dmem_wdata = ex_wdata << (8*addr[2:0]).
REQ-027 Load: shift captured rdata right by 8*addr[2:0], keep size bytes, extend per ex_ext to 64 bits; ld_data SHALL hold its value until the next load completes.
REQ-028 A cycle counter SHALL clear on entry to REQ and increment each cycle in REQ/WAIT_RSP; on reaching TIMEOUT, bus_err_o SHALL pulse one cycle, dmem_req SHALL drop, and the FSM SHALL return to IDLE with ld_valid not asserted.
REQ-029 Latency with gnt and rvalid immediate: store DONE 2 cycles after accept, load DONE 3 cycles after accept.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, counter 0, and dmem_req, dmem_we, stall_o, ld_valid, misalign_o, bus_err_o to 0; dmem_be to 00h; dmem_addr, dmem_wdata, ld_data to 0.
REQ-031 Reset asserted mid-access SHALL abandon the access without a completion or error pulse; a later dmem_rvalid SHALL be ignored.

Verification
REQ-032 Word load, addr 0x1004, ext=0, gnt cycle 1, rdata 0x80000001_00000000 cycle 2 -> ld_valid cycle 3, ld_data=0xFFFFFFFF80000001, stall_o low cycle 3.
REQ-033 Byte store, addr 0x2003, wdata 0xAB -> dmem_be=08h, dmem_wdata[31:24]=ABh, dmem_addr=0x2000, DONE 2 cycles after accept with gnt immediate.
REQ-034 Half load at addr 0x11 -> misalign_o pulse, no dmem_req, stall_o 0, FSM IDLE.
REQ-035 Load with gnt held low for 3 cycles -> dmem_req and dmem_addr/be/wdata/we stable through all 4 REQ cycles; completion follows.
REQ-036 gnt given, rvalid never arrives, TIMEOUT=8 -> bus_err_o pulse, IDLE, ld_valid never asserted.
REQ-037 rst_n pulsed low during WAIT_RSP, rvalid after release -> outputs at reset values, no ld_valid.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller for the MEM stage: lane steering, alignment checks,
// a request/response handshake with timeout, and load extraction/extension.
module dmem_access_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        ex_mem_rd,
  input  logic        ex_mem_wr,
  input  logic [63:0] ex_addr,
  input  logic [63:0] ex_wdata,
  input  logic [1:0]  ex_unit,
  input  logic        ex_ext,
  output logic        stall_o,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [7:0]  dmem_be,
  output logic [63:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [63:0] dmem_rdata,
  output logic [63:0] ld_data,
  output logic        ld_valid,
  output logic        misalign_o,
  output logic        bus_err_o
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] REQ      = 2'd1;
  localparam logic [1:0] WAIT_RSP = 2'd2;
  localparam logic [1:0] DONE     = 2'd3;

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  function automatic logic is_misaligned(input logic [1:0] unit, input logic [2:0] off);
    case (unit)
      2'b00:   return 1'b0;
      2'b01:   return off[0];
      2'b10:   return |off[1:0];
      default: return |off;
    endcase
  endfunction

  function automatic logic [7:0] lane_be(input logic [1:0] unit, input logic [2:0] off);
    logic [7:0] m;
    case (unit)
      2'b00:   m = 8'h01;
      2'b01:   m = 8'h03;
      2'b10:   m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << off;
  endfunction

  // Bring the addressed lane down to bit 0, then keep the access size and extend.
  function automatic logic [63:0] load_extract(input logic [63:0] rdata, input logic [2:0] off,
                                               input logic [1:0] unit, input logic ext);
    logic [63:0] sh;
    logic signed [63:0] r;
    sh = rdata >> {off, 3'b000};
    case (unit)
      2'b00:   r = ext ? {56'd0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
      2'b01:   r = ext ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      2'b10:   r = ext ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      default: r = sh;
    endcase
    return r;
  endfunction

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    off_q;
  logic [1:0]    unit_q;
  logic          ext_q;
  logic          load_q;
  logic          access;
  logic          misal;
  logic          accept;
  logic          timed_out;

  assign access    = ex_valid & (ex_mem_rd | ex_mem_wr);
  assign misal     = is_misaligned(ex_unit, ex_addr[2:0]);
  assign accept    = (state == IDLE) & access & ~misal;
  assign timed_out = (cnt == CNT_LAST);

  assign stall_o  = (state == REQ) | (state == WAIT_RSP) | accept;
  assign dmem_req = (state == REQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      off_q      <= '0;
      unit_q     <= '0;
      ext_q      <= 1'b0;
      load_q     <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      ld_data    <= '0;
      ld_valid   <= 1'b0;
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
    end else begin
      ld_valid   <= 1'b0;
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            // A request with both read and write set is handled as a load.
            load_q     <= ex_mem_rd;
            dmem_we    <= ~ex_mem_rd;
            dmem_addr  <= {ex_addr[63:3], 3'b000};
            dmem_be    <= lane_be(ex_unit, ex_addr[2:0]);
            dmem_wdata <= ex_wdata << {ex_addr[2:0], 3'b000};
            off_q      <= ex_addr[2:0];
            unit_q     <= ex_unit;
            ext_q      <= ex_ext;
            cnt        <= '0;
            state      <= REQ;
          end else if (access) begin
            misalign_o <= 1'b1;
          end
        end
        REQ: begin
          if (dmem_gnt) begin
            state <= load_q ? WAIT_RSP : DONE;
            cnt   <= cnt + CW'(1);
          end else if (timed_out) begin
            state     <= IDLE;
            bus_err_o <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_RSP: begin
          if (dmem_rvalid) begin
            ld_data  <= load_extract(dmem_rdata, off_q, unit_q, ext_q);
            ld_valid <= 1'b1;
            state    <= DONE;
          end else if (timed_out) begin
            state     <= IDLE;
            bus_err_o <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: loads, stores, misalignment, grant delay,
// timeout and asynchronous reset during an access.
module tb_dmem_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_mem_rd;
  logic        ex_mem_wr;
  logic [63:0] ex_addr;
  logic [63:0] ex_wdata;
  logic [1:0]  ex_unit;
  logic        ex_ext;
  logic        stall_o;
  logic        dmem_req;
  logic        dmem_we;
  logic [63:0] dmem_addr;
  logic [7:0]  dmem_be;
  logic [63:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [63:0] dmem_rdata;
  logic [63:0] ld_data;
  logic        ld_valid;
  logic        misalign_o;
  logic        bus_err_o;

  int checks = 0;
  int errors = 0;

  dmem_access_ctrl #(.TIMEOUT(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ex_valid   (ex_valid),
    .ex_mem_rd  (ex_mem_rd),
    .ex_mem_wr  (ex_mem_wr),
    .ex_addr    (ex_addr),
    .ex_wdata   (ex_wdata),
    .ex_unit    (ex_unit),
    .ex_ext     (ex_ext),
    .stall_o    (stall_o),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_be    (dmem_be),
    .dmem_wdata (dmem_wdata),
    .dmem_gnt   (dmem_gnt),
    .dmem_rvalid(dmem_rvalid),
    .dmem_rdata (dmem_rdata),
    .ld_data    (ld_data),
    .ld_valid   (ld_valid),
    .misalign_o (misalign_o),
    .bus_err_o  (bus_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    ex_valid    = 1'b0;
    ex_mem_rd   = 1'b0;
    ex_mem_wr   = 1'b0;
    ex_addr     = '0;
    ex_wdata    = '0;
    ex_unit     = 2'b00;
    ex_ext      = 1'b0;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = '0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (stall_o !== 1'b0)     begin errors++; $display("FAIL rst_stall: got %b expected 0", stall_o); end
    checks++; if (dmem_req !== 1'b0)    begin errors++; $display("FAIL rst_req: got %b expected 0", dmem_req); end
    checks++; if (dmem_we !== 1'b0)     begin errors++; $display("FAIL rst_we: got %b expected 0", dmem_we); end
    checks++; if (dmem_be !== 8'h00)    begin errors++; $display("FAIL rst_be: got %h expected 00", dmem_be); end
    checks++; if (dmem_addr !== 64'd0)  begin errors++; $display("FAIL rst_addr: got %h expected 0", dmem_addr); end
    checks++; if (dmem_wdata !== 64'd0) begin errors++; $display("FAIL rst_wdata: got %h expected 0", dmem_wdata); end
    checks++; if (ld_data !== 64'd0)    begin errors++; $display("FAIL rst_ld_data: got %h expected 0", ld_data); end
    checks++; if (ld_valid !== 1'b0)    begin errors++; $display("FAIL rst_ld_valid: got %b expected 0", ld_valid); end
    checks++; if (misalign_o !== 1'b0)  begin errors++; $display("FAIL rst_misalign: got %b expected 0", misalign_o); end
    checks++; if (bus_err_o !== 1'b0)   begin errors++; $display("FAIL rst_bus_err: got %b expected 0", bus_err_o); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_word_load;
    ex_valid = 1'b1; ex_mem_rd = 1'b1; ex_addr = 64'h1004; ex_unit = 2'b10; ex_ext = 1'b0;
    #1;
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL wl_accept_stall: got %b expected 1", stall_o); end
    tick();
    ex_valid = 1'b0; ex_mem_rd = 1'b0;
    checks++; if (dmem_req !== 1'b1)         begin errors++; $display("FAIL wl_req: got %b expected 1", dmem_req); end
    checks++; if (dmem_addr !== 64'h1000)    begin errors++; $display("FAIL wl_addr: got %h expected 1000", dmem_addr); end
    checks++; if (dmem_be !== 8'hF0)         begin errors++; $display("FAIL wl_be: got %h expected f0", dmem_be); end
    checks++; if (dmem_we !== 1'b0)          begin errors++; $display("FAIL wl_we: got %b expected 0", dmem_we); end
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL wl_wait_req: got %b expected 0", dmem_req); end
    checks++; if (stall_o !== 1'b1)  begin errors++; $display("FAIL wl_wait_stall: got %b expected 1", stall_o); end
    dmem_rvalid = 1'b1; dmem_rdata = 64'h80000001_00000000;
    tick();
    dmem_rvalid = 1'b0; dmem_rdata = '0;
    checks++; if (ld_valid !== 1'b1)                 begin errors++; $display("FAIL wl_ld_valid: got %b expected 1", ld_valid); end
    checks++; if (ld_data !== 64'hFFFFFFFF80000001)  begin errors++; $display("FAIL wl_ld_data: got %h expected ffffffff80000001", ld_data); end
    checks++; if (stall_o !== 1'b0)                  begin errors++; $display("FAIL wl_done_stall: got %b expected 0", stall_o); end
    tick();
    checks++; if (ld_valid !== 1'b0)                 begin errors++; $display("FAIL wl_ld_valid_drop: got %b expected 0", ld_valid); end
    checks++; if (ld_data !== 64'hFFFFFFFF80000001)  begin errors++; $display("FAIL wl_ld_data_hold: got %h expected ffffffff80000001", ld_data); end
  endtask

  task automatic test_byte_store;
    ex_valid = 1'b1; ex_mem_wr = 1'b1; ex_addr = 64'h2003; ex_unit = 2'b00; ex_wdata = 64'hAB;
    tick();
    ex_valid = 1'b0; ex_mem_wr = 1'b0;
    checks++; if (dmem_req !== 1'b1)                 begin errors++; $display("FAIL bs_req: got %b expected 1", dmem_req); end
    checks++; if (dmem_we !== 1'b1)                  begin errors++; $display("FAIL bs_we: got %b expected 1", dmem_we); end
    checks++; if (dmem_be !== 8'h08)                 begin errors++; $display("FAIL bs_be: got %h expected 08", dmem_be); end
    checks++; if (dmem_addr !== 64'h2000)            begin errors++; $display("FAIL bs_addr: got %h expected 2000", dmem_addr); end
    checks++; if (dmem_wdata !== 64'h00000000AB000000) begin errors++; $display("FAIL bs_wdata: got %h expected ab000000", dmem_wdata); end
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    checks++; if (stall_o !== 1'b0)  begin errors++; $display("FAIL bs_done_stall: got %b expected 0", stall_o); end
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL bs_done_req: got %b expected 0", dmem_req); end
    checks++; if (ld_valid !== 1'b0) begin errors++; $display("FAIL bs_no_ld_valid: got %b expected 0", ld_valid); end
    tick();
  endtask

  task automatic test_misalign;
    logic [63:0] addrs [3];
    logic [1:0]  units [3];
    addrs[0] = 64'h11;   units[0] = 2'b01;
    addrs[1] = 64'h1006; units[1] = 2'b10;
    addrs[2] = 64'h1004; units[2] = 2'b11;
    for (int i = 0; i < 3; i++) begin
      ex_valid = 1'b1; ex_mem_rd = 1'b1; ex_addr = addrs[i]; ex_unit = units[i];
      #1;
      checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL ma_stall[%0d]: got %b expected 0", i, stall_o); end
      tick();
      ex_valid = 1'b0; ex_mem_rd = 1'b0;
      checks++; if (misalign_o !== 1'b1) begin errors++; $display("FAIL ma_pulse[%0d]: got %b expected 1", i, misalign_o); end
      checks++; if (dmem_req !== 1'b0)   begin errors++; $display("FAIL ma_req[%0d]: got %b expected 0", i, dmem_req); end
      tick();
      checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL ma_pulse_end[%0d]: got %b expected 0", i, misalign_o); end
      checks++; if (dmem_req !== 1'b0)   begin errors++; $display("FAIL ma_req_after[%0d]: got %b expected 0", i, dmem_req); end
    end
  endtask

  task automatic test_gnt_delay;
    ex_valid = 1'b1; ex_mem_rd = 1'b1; ex_addr = 64'h3008; ex_unit = 2'b11; ex_ext = 1'b1;
    ex_wdata = 64'h5555;
    tick();
    ex_valid = 1'b0; ex_mem_rd = 1'b0; ex_addr = 64'hFFFF; ex_wdata = 64'h1234;
    for (int i = 0; i < 4; i++) begin
      checks++; if (dmem_req !== 1'b1)          begin errors++; $display("FAIL gd_req[%0d]: got %b expected 1", i, dmem_req); end
      checks++; if (dmem_addr !== 64'h3008)     begin errors++; $display("FAIL gd_addr[%0d]: got %h expected 3008", i, dmem_addr); end
      checks++; if (dmem_be !== 8'hFF)          begin errors++; $display("FAIL gd_be[%0d]: got %h expected ff", i, dmem_be); end
      checks++; if (dmem_wdata !== 64'h5555)    begin errors++; $display("FAIL gd_wdata[%0d]: got %h expected 5555", i, dmem_wdata); end
      checks++; if (dmem_we !== 1'b0)           begin errors++; $display("FAIL gd_we[%0d]: got %b expected 0", i, dmem_we); end
      dmem_gnt = (i == 3);
      tick();
    end
    dmem_gnt = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 64'h0123456789ABCDEF;
    tick();
    dmem_rvalid = 1'b0;
    checks++; if (ld_valid !== 1'b1)                begin errors++; $display("FAIL gd_ld_valid: got %b expected 1", ld_valid); end
    checks++; if (ld_data !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL gd_ld_data: got %h expected 0123456789abcdef", ld_data); end
    tick();
  endtask

  task automatic test_load_ext;
    logic [63:0] addrs [4];
    logic [1:0]  units [4];
    logic        exts  [4];
    logic [63:0] rdat  [4];
    logic [63:0] expd  [4];
    addrs[0] = 64'h4006; units[0] = 2'b01; exts[0] = 1'b1; rdat[0] = 64'h8765000000000000; expd[0] = 64'h0000000000008765;
    addrs[1] = 64'h4006; units[1] = 2'b01; exts[1] = 1'b0; rdat[1] = 64'h8765000000000000; expd[1] = 64'hFFFFFFFFFFFF8765;
    addrs[2] = 64'h4005; units[2] = 2'b00; exts[2] = 1'b0; rdat[2] = 64'h00009A0000000000; expd[2] = 64'hFFFFFFFFFFFFFF9A;
    addrs[3] = 64'h4000; units[3] = 2'b10; exts[3] = 1'b1; rdat[3] = 64'hFFFFFFFFF0000001; expd[3] = 64'h00000000F0000001;
    for (int i = 0; i < 4; i++) begin
      ex_valid = 1'b1; ex_mem_rd = 1'b1; ex_addr = addrs[i]; ex_unit = units[i]; ex_ext = exts[i];
      tick();
      ex_valid = 1'b0; ex_mem_rd = 1'b0; dmem_gnt = 1'b1;
      tick();
      dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = rdat[i];
      tick();
      dmem_rvalid = 1'b0;
      checks++; if (ld_valid !== 1'b1)  begin errors++; $display("FAIL le_ld_valid[%0d]: got %b expected 1", i, ld_valid); end
      checks++; if (ld_data !== expd[i]) begin errors++; $display("FAIL le_ld_data[%0d]: got %h expected %h", i, ld_data, expd[i]); end
      tick();
    end
  endtask

  task automatic test_back_to_back;
    ex_valid = 1'b1; ex_mem_wr = 1'b1; ex_addr = 64'h5010; ex_unit = 2'b11; ex_wdata = 64'hCAFE;
    tick();
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    checks++; if (stall_o !== 1'b0)  begin errors++; $display("FAIL bb_done_stall: got %b expected 0", stall_o); end
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL bb_done_req: got %b expected 0", dmem_req); end
    ex_mem_rd = 1'b1; ex_addr = 64'h6000;
    tick();
    checks++; if (stall_o !== 1'b1)  begin errors++; $display("FAIL bb_idle_accept: got %b expected 1", stall_o); end
    tick();
    ex_valid = 1'b0; ex_mem_rd = 1'b0; ex_mem_wr = 1'b0;
    checks++; if (dmem_req !== 1'b1)       begin errors++; $display("FAIL bb_req2: got %b expected 1", dmem_req); end
    checks++; if (dmem_we !== 1'b0)        begin errors++; $display("FAIL bb_rdwr_is_load: got %b expected 0", dmem_we); end
    checks++; if (dmem_addr !== 64'h6000)  begin errors++; $display("FAIL bb_addr2: got %h expected 6000", dmem_addr); end
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL bb_wait_stall: got %b expected 1", stall_o); end
    dmem_rvalid = 1'b1; dmem_rdata = 64'hA5A5A5A5_5A5A5A5A;
    tick();
    dmem_rvalid = 1'b0;
    checks++; if (ld_valid !== 1'b1)                  begin errors++; $display("FAIL bb_ld_valid: got %b expected 1", ld_valid); end
    checks++; if (ld_data !== 64'hA5A5A5A55A5A5A5A)   begin errors++; $display("FAIL bb_ld_data: got %h expected a5a5a5a55a5a5a5a", ld_data); end
    tick();
  endtask

  task automatic test_timeout;
    int n;
    ex_valid = 1'b1; ex_mem_rd = 1'b1; ex_addr = 64'h5000; ex_unit = 2'b11; ex_ext = 1'b0;
    tick();
    ex_valid = 1'b0; ex_mem_rd = 1'b0; dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    n = 0;
    while (bus_err_o !== 1'b1 && n < 20) begin
      checks++; if (ld_valid !== 1'b0) begin errors++; $display("FAIL to_ld_valid[%0d]: got %b expected 0", n, ld_valid); end
      tick();
      n++;
    end
    checks++; if (bus_err_o !== 1'b1) begin errors++; $display("FAIL to_bus_err: got %b expected 1 (no pulse within 20 cycles)", bus_err_o); end
    checks++; if (n !== 7)            begin errors++; $display("FAIL to_latency: got %0d cycles expected 7", n); end
    checks++; if (stall_o !== 1'b0)   begin errors++; $display("FAIL to_stall: got %b expected 0", stall_o); end
    checks++; if (dmem_req !== 1'b0)  begin errors++; $display("FAIL to_req: got %b expected 0", dmem_req); end
    checks++; if (ld_valid !== 1'b0)  begin errors++; $display("FAIL to_no_ld_valid: got %b expected 0", ld_valid); end
    dmem_rvalid = 1'b1; dmem_rdata = 64'h1111;
    tick();
    dmem_rvalid = 1'b0;
    checks++; if (bus_err_o !== 1'b0) begin errors++; $display("FAIL to_pulse_end: got %b expected 0", bus_err_o); end
    checks++; if (ld_valid !== 1'b0)  begin errors++; $display("FAIL to_late_rvalid: got %b expected 0", ld_valid); end
    checks++; if (ld_data !== 64'hA5A5A5A55A5A5A5A) begin errors++; $display("FAIL to_ld_data_hold: got %h expected a5a5a5a55a5a5a5a", ld_data); end
  endtask

  task automatic test_reset_mid;
    ex_valid = 1'b1; ex_mem_rd = 1'b1; ex_addr = 64'h7000; ex_unit = 2'b11; ex_wdata = 64'h77;
    tick();
    ex_valid = 1'b0; ex_mem_rd = 1'b0; dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (stall_o !== 1'b0)    begin errors++; $display("FAIL rm_stall: got %b expected 0", stall_o); end
    checks++; if (dmem_addr !== 64'd0) begin errors++; $display("FAIL rm_addr: got %h expected 0", dmem_addr); end
    checks++; if (dmem_be !== 8'h00)   begin errors++; $display("FAIL rm_be: got %h expected 00", dmem_be); end
    checks++; if (ld_data !== 64'd0)   begin errors++; $display("FAIL rm_ld_data: got %h expected 0", ld_data); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    dmem_rvalid = 1'b1; dmem_rdata = 64'hDEADBEEF_DEADBEEF;
    tick();
    dmem_rvalid = 1'b0;
    checks++; if (ld_valid !== 1'b0)  begin errors++; $display("FAIL rm_late_rvalid: got %b expected 0", ld_valid); end
    checks++; if (ld_data !== 64'd0)  begin errors++; $display("FAIL rm_ld_data_after: got %h expected 0", ld_data); end
    tick();
    checks++; if (ld_valid !== 1'b0)  begin errors++; $display("FAIL rm_ld_valid2: got %b expected 0", ld_valid); end
    checks++; if (bus_err_o !== 1'b0) begin errors++; $display("FAIL rm_bus_err: got %b expected 0", bus_err_o); end
    checks++; if (stall_o !== 1'b0)   begin errors++; $display("FAIL rm_stall_after: got %b expected 0", stall_o); end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_store();
    test_misalign();
    test_gnt_delay();
    test_load_ext();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
